// File: rtl/nw_pkg.sv
// ============================================================================
// Module : nw_pkg
// Brief  : Shared Needleman-Wunsch types: arrow codes, column ops, FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nw_pkg;

    localparam logic [2:0] ARROW_LX   = 3'b100;
    localparam logic [2:0] ARROW_UP   = 3'b010;
    localparam logic [2:0] ARROW_DIAG = 3'b001;

    typedef enum logic [1:0] {
        OP_DIAG = 2'd0,
        OP_UP   = 2'd1,
        OP_LX   = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Scoring used by the matrix-fill cells; kept here so both sides agree.
    localparam int MATCH_SCORE    = 1;
    localparam int MISMATCH_SCORE = -1;
    localparam int GAP_SCORE      = -1;

endpackage

`default_nettype wire

// File: rtl/nw_traceback_if.sv
// ============================================================================
// Module : nw_traceback_if
// Brief  : Direction-memory read port plus alignment-column output stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nw_traceback_if #(
    parameter int IDX_W  = 7,
    parameter int ADDR_W = 13
);
    import nw_pkg::*;

    logic              dir_rd_en;
    logic [ADDR_W-1:0] dir_addr;
    logic [2:0]        dir_data;
    logic              out_valid;
    logic              out_ready;
    op_t               out_op;
    logic [IDX_W-1:0]  out_a_idx;
    logic [IDX_W-1:0]  out_b_idx;
    logic              out_last;

    modport master (
        output dir_rd_en, dir_addr,
        input  dir_data,
        output out_valid, out_op, out_a_idx, out_b_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  dir_rd_en, dir_addr,
        output dir_data,
        input  out_valid, out_op, out_a_idx, out_b_idx, out_last,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/nw_tb_addr.sv
// ============================================================================
// Module : nw_tb_addr
// Brief  : Row-major (i,j) -> direction-memory address, shared with the writer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nw_tb_addr #(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = $clog2(MAX_LEN + 1),
    parameter int ADDR_W  = $clog2((MAX_LEN + 1) ** 2)
) (
    input  logic [IDX_W-1:0]  i,
    input  logic [IDX_W-1:0]  j,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] c_row = ADDR_W'(MAX_LEN + 1);

    assign addr = ADDR_W'(i) * c_row + ADDR_W'(j);

endmodule

`default_nettype wire

// File: rtl/nw_traceback.sv
// ============================================================================
// Module : nw_traceback
// Brief  : Needleman-Wunsch traceback walker from (len_a,len_b) back to (0,0).
//          Define NW_TB_STATS_EN to add per-op column counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nw_traceback
    import nw_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = $clog2(MAX_LEN + 1),
    parameter int ADDR_W  = $clog2((MAX_LEN + 1) ** 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] len_a,
    input  logic [IDX_W-1:0] len_b,
    output logic             busy,
    output logic             done,
    output logic             error,
    nw_traceback_if.master   bus
`ifdef NW_TB_STATS_EN
    ,
    output logic [IDX_W:0]   n_match,
    output logic [IDX_W:0]   n_up,
    output logic [IDX_W:0]   n_lx
`endif
);

    localparam logic [IDX_W-1:0] c_max = IDX_W'(MAX_LEN);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_a_idx;
    logic [IDX_W-1:0] r_b_idx;
    op_t              r_op;
    logic             r_last;
    logic             r_error;

    logic             w_arrow_ok;
    op_t              w_arrow_op;
    op_t              w_mv_op;
    logic [IDX_W-1:0] w_ni;
    logic [IDX_W-1:0] w_nj;
    logic             w_fire;
    logic             w_load;

    always_comb begin
        w_arrow_ok = 1'b1;
        w_arrow_op = OP_DIAG;
        case (bus.dir_data)
            ARROW_DIAG: w_arrow_op = OP_DIAG;
            ARROW_UP:   w_arrow_op = OP_UP;
            ARROW_LX:   w_arrow_op = OP_LX;
            default:    w_arrow_ok = 1'b0;
        endcase
    end

    // At a border the move is forced; otherwise it comes from the fetched arrow.
    assign w_mv_op = (r_state == ST_CHECK) ? ((r_i == '0) ? OP_LX : OP_UP) : w_arrow_op;
    assign w_ni    = (w_mv_op == OP_LX) ? r_i : r_i - 1'b1;
    assign w_nj    = (w_mv_op == OP_UP) ? r_j : r_j - 1'b1;
    assign w_fire  = (r_state == ST_EMIT) && bus.out_ready;
    assign w_load  = (w_next == ST_EMIT) && (r_state != ST_EMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CHECK;
            ST_CHECK: begin
                if (r_i == '0 && r_j == '0)      w_next = ST_DONE;
                else if (r_i == '0 || r_j == '0) w_next = ST_EMIT;
                else                             w_next = ST_READ;
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = w_arrow_ok ? ST_EMIT : ST_ERR;
            ST_EMIT:  if (bus.out_ready) w_next = r_last ? ST_DONE : ST_CHECK;
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i     <= '0;
            r_j     <= '0;
            r_a_idx <= '0;
            r_b_idx <= '0;
            r_op    <= OP_DIAG;
            r_last  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_i     <= (len_a > c_max) ? c_max : len_a;
                r_j     <= (len_b > c_max) ? c_max : len_b;
                r_error <= 1'b0;
            end
            if (r_state == ST_WAIT && !w_arrow_ok) r_error <= 1'b1;
            if (w_load) begin
                r_op    <= w_mv_op;
                r_a_idx <= r_i - 1'b1;
                r_b_idx <= r_j - 1'b1;
                r_last  <= (w_ni == '0) && (w_nj == '0);
            end
            if (w_fire) begin
                if (r_op != OP_LX) r_i <= r_i - 1'b1;
                if (r_op != OP_UP) r_j <= r_j - 1'b1;
            end
        end
    end

`ifdef NW_TB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (r_state == ST_IDLE && start)) begin
            n_match <= '0;
            n_up    <= '0;
            n_lx    <= '0;
        end else if (w_fire) begin
            case (r_op)
                OP_DIAG: n_match <= n_match + 1'b1;
                OP_UP:   n_up    <= n_up + 1'b1;
                default: n_lx    <= n_lx + 1'b1;
            endcase
        end
    end
`endif

    nw_tb_addr #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W),
        .ADDR_W  (ADDR_W)
    ) u_addr (
        .i    (r_i),
        .j    (r_j),
        .addr (bus.dir_addr)
    );

    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign error         = r_error;
    assign bus.dir_rd_en = (r_state == ST_READ);
    assign bus.out_valid = (r_state == ST_EMIT);
    assign bus.out_last  = (r_state == ST_EMIT) && r_last;
    assign bus.out_op    = r_op;
    assign bus.out_a_idx = r_a_idx;
    assign bus.out_b_idx = r_b_idx;

endmodule

`default_nettype wire
